// File: rtl/tcni_pkg.sv
// ---------------------------------------------------------------------------
// tcni_pkg
// Shared definitions for the TCNI receiver (and sender):
//   - tcni_recv_state : receiver FSM state encoding
//   - STATUS_*        : status codes presented on the receiver status port
//   - HDR_LEN_LSB     : low bit of the payload length field in a header flit
//   - WB_WORD/WB_NONE : byte write-enable patterns
//   - to_status()     : maps a receiver state to its status code
// ---------------------------------------------------------------------------
package tcni_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RECV     = 3'd1,
    ST_DONE     = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_OVERFLOW = 3'd4
  } tcni_recv_state;

  localparam logic [2:0] STATUS_IDLE     = 3'd0;
  localparam logic [2:0] STATUS_RECV     = 3'd1;
  localparam logic [2:0] STATUS_DONE     = 3'd2;
  localparam logic [2:0] STATUS_DRAIN    = 3'd3;
  localparam logic [2:0] STATUS_OVERFLOW = 3'd4;

  // Length field occupies [HDR_LEN_LSB +: LEN_WIDTH] of the header flit;
  // everything above it is ignored.
  localparam int HDR_LEN_LSB = 0;

  localparam logic [3:0] WB_WORD = 4'b1111;
  localparam logic [3:0] WB_NONE = 4'b0000;

  function automatic logic [2:0] to_status(input tcni_recv_state st);
    logic [2:0] code;
    code = STATUS_IDLE;
    case (st)
      ST_IDLE:     code = STATUS_IDLE;
      ST_RECV:     code = STATUS_RECV;
      ST_DONE:     code = STATUS_DONE;
      ST_DRAIN:    code = STATUS_DRAIN;
      ST_OVERFLOW: code = STATUS_OVERFLOW;
      default:     code = STATUS_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/tcni_cycle_counter.sv
// ---------------------------------------------------------------------------
// tcni_cycle_counter
// Free-running cycle counter, increments every clock and wraps to 0.
// Shared between the TCNI receiver and sender for timestamps.
// Ports:
//   clock_in  - clock
//   reset_in  - asynchronous, active-high reset (clears the count)
//   count_out - current count
// ---------------------------------------------------------------------------
module tcni_cycle_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock_in,
  input  logic             reset_in,
  output logic [WIDTH-1:0] count_out
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q + WIDTH'(1);
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_out = count_q;

endmodule

// File: rtl/tcni_receiver.sv
// ---------------------------------------------------------------------------
// tcni_receiver
// Receives packets (header flit + <length> payload flits) from the network
// and writes the payload as consecutive words into a software-provided
// receive buffer. Packets longer than the buffer are drained and flagged as
// overflow. Software releases DONE/OVERFLOW with ack_in.
//
// Optional feature macro: TCNI_RECV_TIMESTAMP_EN
//   defined   -> recv_time_out holds the cycle count at header acceptance
//   undefined -> recv_time_out is constant 0 (no capture register)
//
// Ports:
//   clock_in, reset_in    - clock, asynchronous active-high reset
//   flit_in/_valid_in     - network flit and its valid
//   flit_ready_out        - receiver can accept a flit
//   addr_out/data_out     - memory byte address / write data (registered)
//   wb_out                - byte write enables, 4'b1111 for one cycle per write
//   buffer_location_in    - word-aligned receive buffer base (MMIO)
//   buffer_size_in        - buffer capacity in words (MMIO)
//   ack_in                - software releases a completed/overflowed packet
//   status                - receiver state code
//   recv_size_out         - length field of the last header
//   recv_time_out         - header arrival timestamp (see macro above)
// ---------------------------------------------------------------------------
module tcni_receiver
  import tcni_pkg::*;
#(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int LEN_WIDTH        = 16
) (
  input  logic                          clock_in,
  input  logic                          reset_in,
  input  logic [MEMORY_BUS_WIDTH-1:0]   flit_in,
  input  logic                          flit_valid_in,
  output logic                          flit_ready_out,
  output logic [MEMORY_BUS_WIDTH-1:0]   addr_out,
  output logic [MEMORY_BUS_WIDTH-1:0]   data_out,
  output logic [3:0]                    wb_out,
  input  logic [MEMORY_BUS_WIDTH-1:2]   buffer_location_in,
  input  logic [LEN_WIDTH-1:0]          buffer_size_in,
  input  logic                          ack_in,
  output logic [2:0]                    status,
  output logic [LEN_WIDTH-1:0]          recv_size_out,
  output logic [MEMORY_BUS_WIDTH-1:0]   recv_time_out
);

  localparam int W = MEMORY_BUS_WIDTH;

  tcni_recv_state       state_d,     state_q;
  logic [W-1:2]         base_d,      base_q;
  logic [LEN_WIDTH-1:0] len_d,       len_q;
  logic [LEN_WIDTH-1:0] idx_d,       idx_q;
  logic [LEN_WIDTH-1:0] recv_size_d, recv_size_q;
  logic [W-1:0]         addr_d,      addr_q;
  logic [W-1:0]         data_d,      data_q;
  logic [3:0]           wb_d,        wb_q;

  logic [W-1:0]         cycle_count;
  logic                 accept;
  logic [LEN_WIDTH-1:0] hdr_len;
  logic [LEN_WIDTH-1:0] idx_inc;

  tcni_cycle_counter #(
    .WIDTH (W)
  ) u_cycle_counter (
    .clock_in  (clock_in),
    .reset_in  (reset_in),
    .count_out (cycle_count)
  );

  // Ready depends only on registered state, gated low while in reset.
  assign flit_ready_out = ~reset_in &
                          ((state_q == ST_IDLE) | (state_q == ST_RECV) |
                           (state_q == ST_DRAIN));
  assign accept  = flit_valid_in & flit_ready_out;
  assign hdr_len = flit_in[HDR_LEN_LSB +: LEN_WIDTH];
  assign idx_inc = idx_q + LEN_WIDTH'(1);

`ifdef TCNI_RECV_TIMESTAMP_EN
  logic [W-1:0] time_d, time_q;
`else
  // The counter is still built for REQ-level reuse; only the capture is dropped.
  logic unused_cycle_count;
  assign unused_cycle_count = ^cycle_count;
`endif

  // NOTE: every signal assigned here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    recv_size_d = recv_size_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wb_d        = WB_NONE;
`ifdef TCNI_RECV_TIMESTAMP_EN
    time_d      = time_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // MMIO values are latched here so later changes do not touch
          // the packet in flight.
          base_d      = buffer_location_in;
          len_d       = hdr_len;
          recv_size_d = hdr_len;
          idx_d       = '0;
`ifdef TCNI_RECV_TIMESTAMP_EN
          time_d      = cycle_count;
`endif
          if (hdr_len == '0)                 state_d = ST_DONE;
          else if (hdr_len > buffer_size_in) state_d = ST_DRAIN;
          else                               state_d = ST_RECV;
        end
      end

      ST_RECV: begin
        if (accept) begin
          // Full-width add so the byte address wraps modulo 2^W.
          addr_d = {base_q, 2'b00} + (W'(idx_q) << 2);
          data_d = flit_in;
          wb_d   = WB_WORD;
          idx_d  = idx_inc;
          if (idx_inc == len_q) state_d = ST_DONE;
        end
      end

      ST_DRAIN: begin
        if (accept) begin
          idx_d = idx_inc;
          if (idx_inc == len_q) state_d = ST_OVERFLOW;
        end
      end

      ST_DONE, ST_OVERFLOW: begin
        if (ack_in) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      recv_size_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wb_q        <= WB_NONE;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      recv_size_q <= recv_size_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wb_q        <= wb_d;
    end
  end

`ifdef TCNI_RECV_TIMESTAMP_EN
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) time_q <= '0;
    else          time_q <= time_d;
  end
  assign recv_time_out = time_q;
`else
  assign recv_time_out = '0;
`endif

  assign addr_out      = addr_q;
  assign data_out      = data_q;
  assign wb_out        = wb_q;
  assign status        = to_status(state_q);
  assign recv_size_out = recv_size_q;

endmodule

// File: tb/tb_tcni_receiver.sv
// ---------------------------------------------------------------------------
// tb_tcni_receiver
// Directed bench for tcni_receiver. Expected memory writes are queued when
// payload flits are driven; a forked monitor pops and compares each write
// the DUT presents. State/status checks are made inline.
// ---------------------------------------------------------------------------
module tb_tcni_receiver;

  localparam int W  = 32;
  localparam int LW = 16;

  logic          clock_in = 1'b0;
  logic          reset_in;
  logic [W-1:0]  flit_in;
  logic          flit_valid_in;
  logic          flit_ready_out;
  logic [W-1:0]  addr_out;
  logic [W-1:0]  data_out;
  logic [3:0]    wb_out;
  logic [W-1:2]  buffer_location_in;
  logic [LW-1:0] buffer_size_in;
  logic          ack_in;
  logic [2:0]    status;
  logic [LW-1:0] recv_size_out;
  logic [W-1:0]  recv_time_out;

  tcni_receiver #(
    .MEMORY_BUS_WIDTH (W),
    .LEN_WIDTH        (LW)
  ) dut (
    .clock_in           (clock_in),
    .reset_in           (reset_in),
    .flit_in            (flit_in),
    .flit_valid_in      (flit_valid_in),
    .flit_ready_out     (flit_ready_out),
    .addr_out           (addr_out),
    .data_out           (data_out),
    .wb_out             (wb_out),
    .buffer_location_in (buffer_location_in),
    .buffer_size_in     (buffer_size_in),
    .ack_in             (ack_in),
    .status             (status),
    .recv_size_out      (recv_size_out),
    .recv_time_out      (recv_time_out)
  );

  always #5 clock_in = ~clock_in;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];   // {addr, data} of expected writes

  // Reference cycle count: value visible in a cycle = posedges since reset.
  logic [W-1:0] model_cnt;
  always @(posedge clock_in or posedge reset_in) begin
    if (reset_in) model_cnt <= '0;
    else          model_cnt <= model_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_time(input logic [W-1:0] t);
`ifdef TCNI_RECV_TIMESTAMP_EN
    return t;
`else
    return (t & '0);
`endif
  endfunction

  task automatic monitor();
    logic [63:0] e;
    forever begin
      @(negedge clock_in);
      if (wb_out !== 4'h0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_wb", {60'h0, wb_out}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", {32'h0, addr_out}, {32'h0, e[63:32]});
          check("write_data", {32'h0, data_out}, {32'h0, e[31:0]});
          check("write_wb",   {60'h0, wb_out},   64'hF);
        end
      end
    end
  endtask

  // Drive one flit from a negedge, hold until ready (bounded), then let the
  // accepting posedge pass. t returns the cycle count of the accept cycle.
  task automatic send_flit(input logic [W-1:0] f, output logic [W-1:0] t);
    int n;
    @(negedge clock_in);
    flit_in       = f;
    flit_valid_in = 1'b1;
    n = 0;
    while (flit_ready_out !== 1'b1 && n < 20) begin
      @(negedge clock_in);
      n++;
    end
    if (flit_ready_out !== 1'b1) check("ready_timeout", {63'h0, flit_ready_out}, 64'h1);
    t = model_cnt;
    @(posedge clock_in);
  endtask

  // Header, then npay payload flits (dbase + k*0x01010101). MMIO inputs are
  // scrambled right after the header to show they no longer matter.
  task automatic send_pkt(input logic [W-1:0] hdr, input int npay,
                          input logic [W-1:0] dbase, input logic [W-1:2] wbase,
                          input bit exp_wr, input bit gap,
                          output logic [W-1:0] t);
    logic [W-1:0] d, a, dummy;
    send_flit(hdr, t);
    @(negedge clock_in);
    flit_valid_in      = 1'b0;
    buffer_location_in = ~buffer_location_in;
    buffer_size_in     = '0;
    for (int k = 0; k < npay; k++) begin
      if (gap && k > 0) begin
        @(negedge clock_in);
        flit_valid_in = 1'b0;
      end
      d = dbase + W'(k) * 32'h0101_0101;
      a = {wbase, 2'b00} + W'(4 * k);
      if (exp_wr) exp_q.push_back({a, d});
      send_flit(d, dummy);
    end
    @(negedge clock_in);
    flit_valid_in = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clock_in);
    ack_in = 1'b1;
    @(negedge clock_in);
    ack_in = 1'b0;
    check("status_after_ack", {61'h0, status}, 64'd0);
  endtask

  initial begin
    logic [W-1:0] t;
    reset_in           = 1'b1;
    flit_in            = '0;
    flit_valid_in      = 1'b0;
    buffer_location_in = '0;
    buffer_size_in     = '0;
    ack_in             = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(negedge clock_in);
    check("rst_status", {61'h0, status}, 64'd0);
    check("rst_ready",  {63'h0, flit_ready_out}, 64'd0);
    check("rst_wb",     {60'h0, wb_out}, 64'd0);
    check("rst_addr",   {32'h0, addr_out}, 64'd0);
    check("rst_size",   {48'h0, recv_size_out}, 64'd0);
    check("rst_time",   {32'h0, recv_time_out}, 64'd0);
    reset_in = 1'b0;
    @(negedge clock_in);
    check("idle_ready", {63'h0, flit_ready_out}, 64'd1);

    // Basic packet: base word 0x100, len 3 -> 0x400/0x404/0x408
    buffer_location_in = 30'h100;
    buffer_size_in     = 16'd8;
    send_pkt(32'h0000_0003, 3, 32'hA0A0_0000, 30'h100, 1'b1, 1'b0, t);
    check("basic_pending",  exp_q.size(), 64'd0);
    check("basic_status",   {61'h0, status}, 64'd2);
    check("basic_size",     {48'h0, recv_size_out}, 64'd3);
    check("basic_ready",    {63'h0, flit_ready_out}, 64'd0);
    check("basic_time",     {32'h0, recv_time_out}, {32'h0, exp_time(t)});
    ack_pulse();

    // Zero-length header (upper bits set and ignored)
    buffer_location_in = 30'h100;
    buffer_size_in     = 16'd8;
    send_pkt(32'hABCD_0000, 0, 32'h0, 30'h100, 1'b0, 1'b0, t);
    check("len0_status", {61'h0, status}, 64'd2);
    check("len0_size",   {48'h0, recv_size_out}, 64'd0);
    repeat (3) @(negedge clock_in);
    check("len0_ready_held", {63'h0, flit_ready_out}, 64'd0);
    check("len0_status_held", {61'h0, status}, 64'd2);
    ack_pulse();

    // Overflow: size 2, len 4 -> drained, no writes
    buffer_location_in = 30'h40;
    buffer_size_in     = 16'd2;
    send_pkt(32'h0000_0004, 4, 32'h5500_0000, 30'h40, 1'b0, 1'b0, t);
    check("ovf_status", {61'h0, status}, 64'd4);
    check("ovf_size",   {48'h0, recv_size_out}, 64'd4);
    check("ovf_ready",  {63'h0, flit_ready_out}, 64'd0);
    ack_pulse();

    // Zero-size buffer: any nonzero length overflows
    buffer_location_in = 30'h40;
    buffer_size_in     = 16'd0;
    send_pkt(32'h0000_0001, 1, 32'h6600_0000, 30'h40, 1'b0, 1'b0, t);
    check("size0_status", {61'h0, status}, 64'd4);
    ack_pulse();

    // Exact fit: size 2, len 2, with idle gaps between payload flits
    buffer_location_in = 30'h20;
    buffer_size_in     = 16'd2;
    send_pkt(32'h0000_0002, 2, 32'h7700_0011, 30'h20, 1'b1, 1'b1, t);
    check("fit_pending", exp_q.size(), 64'd0);
    check("fit_status",  {61'h0, status}, 64'd2);
    ack_pulse();

    // Address wrap: base word 0x3FFFFFFF -> 0xFFFFFFFC then 0x00000000
    buffer_location_in = 30'h3FFF_FFFF;
    buffer_size_in     = 16'd8;
    send_pkt(32'h0000_0002, 2, 32'hC0DE_0000, 30'h3FFF_FFFF, 1'b1, 1'b0, t);
    check("wrap_pending",  exp_q.size(), 64'd0);
    check("wrap_last_addr", {32'h0, addr_out}, 64'h0);
    ack_pulse();

    // Reset after 2 of 5 payload flits
    buffer_location_in = 30'h200;
    buffer_size_in     = 16'd8;
    send_pkt(32'h0000_0005, 2, 32'h1234_0000, 30'h200, 1'b1, 1'b0, t);
    check("mid_status", {61'h0, status}, 64'd1);
    @(posedge clock_in);
    #2 reset_in = 1'b1;
    #1;
    check("mid_rst_status", {61'h0, status}, 64'd0);
    check("mid_rst_ready",  {63'h0, flit_ready_out}, 64'd0);
    check("mid_rst_addr",   {32'h0, addr_out}, 64'd0);
    check("mid_rst_data",   {32'h0, data_out}, 64'd0);
    check("mid_rst_size",   {48'h0, recv_size_out}, 64'd0);
    @(negedge clock_in);
    reset_in = 1'b0;
    check("mid_pending", exp_q.size(), 64'd0);

    // Header accepted at cycle 17 after reset; len 1 packet completes
    buffer_location_in = 30'h10;
    buffer_size_in     = 16'd8;
    repeat (17) @(posedge clock_in);
    send_pkt(32'h0000_0001, 1, 32'hDDDD_0001, 30'h10, 1'b1, 1'b0, t);
    check("post_pending", exp_q.size(), 64'd0);
    check("post_status",  {61'h0, status}, 64'd2);
    check("post_size",    {48'h0, recv_size_out}, 64'd1);
`ifdef TCNI_RECV_TIMESTAMP_EN
    check("post_time", {32'h0, recv_time_out}, 64'd17);
`else
    check("post_time", {32'h0, recv_time_out}, 64'd0);
`endif
    ack_pulse();

    repeat (3) @(negedge clock_in);
    check("final_pending", exp_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/tcni_receiver.md
TCNI_RECEIVER -- requirements
Module: tcni_receiver

Interface
REQ-001 SHALL have parameter MEMORY_BUS_WIDTH, default 32, width of the flit, memory data and memory address buses.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, width of the header length field and of the size registers.
REQ-003 clock_in  input  1  single clock; all logic on posedge; one clock, reset is asynchronous and active-high.
REQ-004 reset_in  input  1  asynchronous, active-high reset.
REQ-005 flit_in  input  MEMORY_BUS_WIDTH  network flit.
REQ-006 flit_valid_in  input  1  flit_in valid.
REQ-007 flit_ready_out  output  1  receiver accepts flit; a transfer occurs when valid and ready are both 1.
REQ-008 addr_out  output  MEMORY_BUS_WIDTH  memory byte address.
REQ-009 data_out  output  MEMORY_BUS_WIDTH  memory write data.
REQ-010 wb_out  output  4  byte write enables (4'b1111 = word write, 0 = idle).
REQ-011 buffer_location_in  input  MEMORY_BUS_WIDTH-2 (bits [W-1:2])  word-aligned receive buffer base (MMIO).
REQ-012 buffer_size_in  input  LEN_WIDTH  buffer capacity in words (MMIO).
REQ-013 ack_in  input  1  software releases a completed or overflowed packet.
REQ-014 status  output  3  receiver state code.
REQ-015 recv_size_out  output  LEN_WIDTH  length field of the last packet.
REQ-016 recv_time_out  output  MEMORY_BUS_WIDTH  arrival timestamp (REQ-032).

Function
REQ-017 Packet format: header flit, with payload length in words at [LEN_WIDTH-1:0] and upper bits ignored, followed by exactly that many payload flits.
REQ-018 States and status codes: IDLE=0, RECV=1, DONE=2, DRAIN=3, OVERFLOW=4.
REQ-019 flit_ready_out SHALL be 1 in IDLE, RECV and DRAIN, and 0 in DONE and OVERFLOW.
REQ-020 IDLE, header accepted: latch buffer_location_in and length, set recv_size_out = length, clear the word index.
- length 0: go to DONE.
- length > buffer_size_in: go to DRAIN.
- otherwise: go to RECV.
REQ-021 RECV, payload flit k accepted (k = 0..length-1):
- Next cycle: addr_out = {latched_base, 2'b00} + 4*k, data_out = flit, wb_out = 4'b1111 for exactly one cycle.
- Write latency is 1 cycle; one write per accepted flit, back-to-back allowed.
REQ-022 RECV, last payload flit accepted: go to DONE; its write is issued in the first DONE cycle.
REQ-023 DRAIN: accept and discard flits with wb_out = 0; after the last payload flit, go to OVERFLOW.
REQ-024 DONE or OVERFLOW with ack_in = 1: go to IDLE next cycle; ack_in in any other state SHALL be ignored.
REQ-025 Address arithmetic SHALL wrap modulo 2^MEMORY_BUS_WIDTH; buffer_size_in = 0 SHALL send any nonzero length to DRAIN.
REQ-026 MMIO input changes after header acceptance SHALL NOT affect the packet in flight.
REQ-027 When no write is issued, wb_out SHALL be 0; addr_out and data_out hold their last values.
REQ-028 A free-running MEMORY_BUS_WIDTH-bit cycle counter SHALL increment every clock and wrap to 0.

Reset
REQ-029 reset_in asserted SHALL immediately set: state IDLE, status 0, wb_out 0, addr_out 0, data_out 0, recv_size_out 0, recv_time_out 0, counter 0, index 0.
REQ-030 flit_ready_out SHALL be 0 while reset_in is high.
REQ-031 Reset mid-packet SHALL abort the packet; memory writes already issued are not undone; the next accepted flit is treated as a header.

Configuration
REQ-032 With TCNI_RECV_TIMESTAMP_EN defined: recv_time_out SHALL capture the counter value in the cycle the header is accepted.
REQ-033 Without TCNI_RECV_TIMESTAMP_EN: recv_time_out SHALL be constant 0, and no capture register is built.

Structure
REQ-034 Package tcni_pkg SHALL hold the state enum tcni_recv_state, the status code constants, and the header length field bounds.
REQ-035 The cycle counter SHALL be sub-module tcni_cycle_counter, reusable by the sender.

Verification
REQ-036 base word 0x100, size 8, packet len 3 with payload A,B,C -> writes 0x400=A, 0x404=B, 0x408=C; status 2; recv_size_out 3.
REQ-037 len 0 header -> status 2 the next cycle, no wb_out pulse, flit_ready_out 0 until ack_in.
REQ-038 size 2, len 4 -> all 4 payload flits accepted, wb_out stays 0, status 4; ack_in -> status 0.
REQ-039 reset_in pulsed after 2 of 5 payload flits -> outputs cleared immediately; a following len 1 packet completes normally.
REQ-040 base word 0x3FFFFFFF, len 2 -> addresses 0xFFFFFFFC, then 0x00000000.
REQ-041 TCNI_RECV_TIMESTAMP_EN defined, header accepted at cycle 17 after reset -> recv_time_out = 17; macro undefined -> recv_time_out = 0.
